// File: rtl/tuple_replace_arbiter.sv
// Shared two-field tuple register with a two-requester replace arbiter (fair on same-field contention).
// Optional `TUPLE_REPLACE_LOCK_EN adds a lock input that freezes all grants and writes.
module tuple_replace_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned INIT0 = 1,
  parameter int unsigned INIT1 = 1
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
`ifdef TUPLE_REPLACE_LOCK_EN
  input  logic             lock,
`endif
  input  logic             I0_valid,
  input  logic             I0_idx,
  input  logic [WIDTH-1:0] I0_data,
  output logic             I0_ready,
  input  logic             I1_valid,
  input  logic             I1_idx,
  input  logic [WIDTH-1:0] I1_data,
  output logic             I1_ready,
  output logic [WIDTH-1:0] O__0,
  output logic [WIDTH-1:0] O__1,
  output logic [1:0]       updated
);

  typedef enum logic {
    PRIO_I0 = 1'b0,
    PRIO_I1 = 1'b1
  } prio_e;

  localparam logic [WIDTH-1:0] RST0 = WIDTH'(INIT0);
  localparam logic [WIDTH-1:0] RST1 = WIDTH'(INIT1);

  prio_e            prio_q, prio_nxt;
  logic [WIDTH-1:0] f0_q, f0_nxt;
  logic [WIDTH-1:0] f1_q, f1_nxt;
  logic [1:0]       upd_q, upd_nxt;
  logic             lock_act;
  logic             contested;
  logic             gnt0, gnt1;

`ifdef TUPLE_REPLACE_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  // Grants are a pure function of valid/idx/prio; ready never feeds back into valid.
  always_comb begin
    contested = I0_valid & I1_valid & (I0_idx == I1_idx);
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (ASYNCRESETN && !lock_act) begin
      if (contested) begin
        gnt0 = (prio_q == PRIO_I0);
        gnt1 = (prio_q == PRIO_I1);
      end else begin
        gnt0 = I0_valid;
        gnt1 = I1_valid;
      end
    end
  end

  assign I0_ready = gnt0;
  assign I1_ready = gnt1;

  // Next-state: field writes, update pulses, and loser-gets-priority on contention.
  always_comb begin
    prio_nxt = prio_q;
    f0_nxt   = f0_q;
    f1_nxt   = f1_q;
    upd_nxt  = 2'b00;
    if (gnt0) begin
      if (I0_idx) f1_nxt = I0_data;
      else        f0_nxt = I0_data;
      upd_nxt[I0_idx] = 1'b1;
    end
    if (gnt1) begin
      if (I1_idx) f1_nxt = I1_data;
      else        f0_nxt = I1_data;
      upd_nxt[I1_idx] = 1'b1;
    end
    if (contested && !lock_act) begin
      prio_nxt = (prio_q == PRIO_I0) ? PRIO_I1 : PRIO_I0;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      prio_q <= PRIO_I0;
      f0_q   <= RST0;
      f1_q   <= RST1;
      upd_q  <= 2'b00;
    end else begin
      prio_q <= prio_nxt;
      f0_q   <= f0_nxt;
      f1_q   <= f1_nxt;
      upd_q  <= upd_nxt;
    end
  end

  assign O__0    = f0_q;
  assign O__1    = f1_q;
  assign updated = upd_q;

endmodule
